// File: rtl/logic_unit_sliced.sv
// logic_unit_sliced: WIDTH-bit bitwise AND/OR/XOR/NOR evaluated SLICE bits per
// clock behind valid/ready handshakes on both the input and the result side.
// Optional macro LOGIC_UNIT_ZERO_FLAG_EN adds a registered 'zero' result flag.
module logic_unit_sliced #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inpA,
    input  logic [WIDTH-1:0] inpB,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NSLICE - 1);

    if ((WIDTH % SLICE) != 0) begin : g_bad_cfg
        $error("logic_unit_sliced: WIDTH must be an integer multiple of SLICE");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [1:0]       op_reg;
    logic [CW-1:0]    cnt;

    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] f_sl;
    logic [WIDTH-1:0] res_next;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Select the current operand slice, apply the op, and form the result with that slice merged in
    always_comb begin
        a_sl     = a_reg[32'(cnt) * SLICE +: SLICE];
        b_sl     = b_reg[32'(cnt) * SLICE +: SLICE];
        f_sl     = '0;
        case (op_reg)
            2'b00:   f_sl = a_sl & b_sl;
            2'b01:   f_sl = a_sl | b_sl;
            2'b10:   f_sl = a_sl ^ b_sl;
            default: f_sl = ~(a_sl | b_sl);
        endcase
        res_next = result;
        res_next[32'(cnt) * SLICE +: SLICE] = f_sl;
    end

    // Handshake FSM: capture in IDLE, one slice per RUN edge, hold result in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            op_reg <= '0;
            cnt    <= '0;
            result <= '0;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
            zero   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg  <= inpA;
                        b_reg  <= inpB;
                        op_reg <= op;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    result <= res_next;
                    if (cnt == LAST_CNT) begin
                        cnt   <= '0;
                        state <= DONE;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
                        // Flag is taken from the merged value, not the stale register
                        zero  <= ~|res_next;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_unit_sliced.sv
// Directed, table-driven bench for logic_unit_sliced (SLICE=8 and SLICE=WIDTH instances).
module tb_logic_unit_sliced;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance 0: WIDTH=32, SLICE=8
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] inpA, inpB, result;
    logic [1:0]  op;
    logic        zero;

    // Instance 1: WIDTH=32, SLICE=32
    logic        in_valid1, in_ready1, out_valid1, out_ready1;
    logic [31:0] inpA1, inpB1, result1;
    logic [1:0]  op1;
    logic        zero1;

    logic_unit_sliced #(.WIDTH(32), .SLICE(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .inpA(inpA), .inpB(inpB), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result)
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
        , .zero(zero)
`endif
    );

    logic_unit_sliced #(.WIDTH(32), .SLICE(32)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .inpA(inpA1), .inpB(inpB1), .op(op1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .result(result1)
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
        , .zero(zero1)
`endif
    );

`ifndef LOGIC_UNIT_ZERO_FLAG_EN
    assign zero  = 1'b0;
    assign zero1 = 1'b0;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] exp_r;
        logic        exp_z;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Full operation on instance 0 with out_ready held high
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] o, input logic [31:0] exp_r, input logic exp_z);
        int unsigned n;
        out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            step;
            n++;
        end
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        inpA = a; inpB = b; op = o; in_valid = 1'b1;
        step;
        // Scramble inputs after capture; the operation must be unaffected
        in_valid = 1'b0; inpA = ~a; inpB = ~b; op = ~o;
        n = 0;
        do begin
            step;
            n++;
        end while (!out_valid && n < 20);
        check({tag, "_latency"}, 64'(n), 64'd4);
        check({tag, "_result"}, 64'(result), 64'(exp_r));
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
        check({tag, "_zero"}, 64'(zero), 64'(exp_z));
`endif
        step;
        check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int unsigned n;
        int unsigned acc_cyc[$];
        logic [31:0] res_q[$];
        int unsigned cyc;

        vecs[0] = '{32'hF0F0_0000, 32'h0000_0F0F, 2'b01, 32'hF0F0_0F0F, 1'b0};
        vecs[1] = '{32'h0000_0000, 32'h0000_0000, 2'b11, 32'hFFFF_FFFF, 1'b0};
        vecs[2] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b10, 32'h0000_0000, 1'b1};
        vecs[3] = '{32'hFFFF_FFFF, 32'h1234_5678, 2'b00, 32'h1234_5678, 1'b0};
        vecs[4] = '{32'h0F0F_0F0F, 32'hF0F0_F0F0, 2'b00, 32'h0000_0000, 1'b1};
        vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0000, 2'b11, 32'h0000_0000, 1'b1};
        vecs[6] = '{32'hA5A5_A5A5, 32'h0F0F_0F0F, 2'b10, 32'hAAAA_AAAA, 1'b0};
        vecs[7] = '{32'h0000_0001, 32'h8000_0000, 2'b01, 32'h8000_0001, 1'b0};

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; inpA = '0; inpB = '0; op = '0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; inpA1 = '0; inpB1 = '0; op1 = '0;

        // Reset state, with in_valid asserted to show nothing is captured
        in_valid = 1'b1; inpA = 32'hFFFF_FFFF; inpB = 32'hFFFF_FFFF;
        step; step;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_zero", 64'(zero), 64'd0);
        check("rst_out_valid1", 64'(out_valid1), 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step;

        // Table-driven operations on the SLICE=8 instance
        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op,
                   vecs[i].exp_r, vecs[i].exp_z);
        end

        // Backpressure: result held, new requests ignored while out_ready=0
        out_ready = 1'b0;
        inpA = 32'h1; inpB = 32'h2; op = 2'b01; in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin step; n++; end
        check("bp_reach_done", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; inpA = 32'hFFFF_0000 + 32'(i); inpB = 32'h0; op = 2'b11;
            step;
            check($sformatf("bp_result%0d", i), 64'(result), 64'h3);
            check($sformatf("bp_in_ready%0d", i), 64'(in_ready), 64'd0);
            check($sformatf("bp_out_valid%0d", i), 64'(out_valid), 64'd1);
        end
        inpA = 32'hF; inpB = 32'h5; op = 2'b10;
        out_ready = 1'b1;
        step;
        check("bp_release_idle", 64'(in_ready), 64'd1);
        check("bp_release_valid", 64'(out_valid), 64'd0);
        step;
        check("bp_new_accept", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin step; n++; end
        check("bp_new_result", 64'(result), 64'hA);
        step;

        // Reset mid-RUN: partial result must vanish asynchronously
        out_ready = 1'b1;
        inpA = 32'hFFFF_FFFF; inpB = 32'h0; op = 2'b01; in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        step; step;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_result", 64'(result), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        step;
        @(negedge clk);
        rst_n = 1'b1;
        step;
        run_op("post_rst_and", 32'hFFFF_FFFF, 32'h1234_5678, 2'b00, 32'h1234_5678, 1'b0);

        // SLICE=WIDTH instance: single-edge latency
        out_ready1 = 1'b1;
        inpA1 = 32'hFFFF_0000; inpB1 = 32'h0FF0_0FF0; op1 = 2'b00; in_valid1 = 1'b1;
        step;
        in_valid1 = 1'b0; inpA1 = '0;
        n = 0;
        do begin step; n++; end while (!out_valid1 && n < 20);
        check("s32_latency", 64'(n), 64'd1);
        check("s32_result", 64'(result1), 64'h0FF0_0000);
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
        check("s32_zero", 64'(zero1), 64'd0);
`endif
        step;
        check("s32_ready_back", 64'(in_ready1), 64'd1);

        // Back-to-back with in_valid and out_ready tied high
        out_ready = 1'b1;
        inpA = 32'h1; inpB = 32'h2; op = 2'b01; in_valid = 1'b1;
        cyc = 0;
        while (res_q.size() < 2 && cyc < 40) begin
            if (in_ready) begin
                acc_cyc.push_back(cyc);
                if (acc_cyc.size() == 1) begin
                    step; cyc++;
                    inpA = 32'hF; inpB = 32'h5; op = 2'b10;
                    continue;
                end
            end
            if (out_valid) res_q.push_back(result);
            step; cyc++;
        end
        in_valid = 1'b0;
        check("b2b_results_count", 64'(res_q.size()), 64'd2);
        check("b2b_accepts_count", 64'(acc_cyc.size() >= 2), 64'd1);
        if (res_q.size() >= 2) begin
            check("b2b_res0", 64'(res_q[0]), 64'h3);
            check("b2b_res1", 64'(res_q[1]), 64'hA);
        end
        if (acc_cyc.size() >= 2) begin
            check("b2b_spacing", 64'(acc_cyc[1] - acc_cyc[0]), 64'd6);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
